adc_multilane_data_sim: RTL and testbench
=========================================

// Module: adc_multilane_data_sim
// PURPOSE
//  Behavioural multi-lane ADC serial-output model for PMU front-end benches; parametrised successor to the fixed 8ch/4-lane model.
//  Each frame it latches N_CH parallel channel words, pulses nDRDY low and shifts the words MSB-first over N_LANES DOUT lines, one bit per CLK.
//  Frame timing is restartable by nSYNC_IN. The model drives the ADC capture/deserialiser RTL under test.
// PARAMETERS
//  N_CH          8    number of channels; N_CH % N_LANES == 0 (elaboration $error otherwise)
//  CH_W          32   bits per channel word; CH_W >= 16
//  N_LANES       4    DOUT lanes; CPL = N_CH/N_LANES channels per lane
//  FRAME_CYCLES  256  CLK cycles per frame; >= CPL*CH_W + 1 (elaboration $error otherwise)
//  SYNC_DELAY    16   CLK cycles from sync release (or reset release) to first nDRDY; >= 1
// PORTS
//  CLK        in   1             model clock; all logic on posedge
//  RST        in   1             synchronous reset, active-high
//  nSYNC_IN   in   1             active-low sync; sampled on CLK, no synchroniser
//  NEXT_DATA  in   [CH_W-1:0] [N_CH-1:0]  channel words, latched at frame start
//  TEST_MODE  in   1             only with ADC_TEST_PATTERN_EN; selects generated pattern
//  nDRDY      out  1             active-low frame strobe, one CLK wide
//  DOUT       out  [N_LANES-1:0] serial data, bit l = lane l
//  FRAME_CNT  out  16            frames started since last sync/reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (RST=1 on a CLK edge): nDRDY=1, DOUT=0, FRAME_CNT=0, state=SYNC_WAIT, delay counter=0; RST overrides everything.
//  States:
//   SYNC_HOLD: nSYNC_IN==0. Outputs idle (nDRDY=1, DOUT=0). Exit to SYNC_WAIT on first cycle nSYNC_IN==1.
//   SYNC_WAIT: count SYNC_DELAY cycles, outputs idle; on last count -> SHIFT with frame start on next edge.
//   SHIFT: frame cycle counter fc = 0..CPL*CH_W-1. At fc=0: latch words, nDRDY=0, DOUT = MSB of first word per lane.
//          nDRDY=1 for fc>=1. Each CLK advances one bit.
//   GAP: fc = CPL*CH_W..FRAME_CYCLES-1, DOUT=0, nDRDY=1. At FRAME_CYCLES-1 -> SHIFT (next frame fc=0).
//  Frame start in the first frame after SYNC_WAIT is exactly SYNC_DELAY cycles after nSYNC_IN rises.
//  Lane map: lane l carries ch l*CPL .. l*CPL+CPL-1, lowest channel first, each MSB-first.
//  Period: nDRDY falls every FRAME_CYCLES cycles exactly; no drift.
//  FRAME_CNT increments at each fc=0 (value visible same cycle as nDRDY=0 is the new count, first frame = 1).
//  nSYNC_IN==0 in any state: next edge -> SYNC_HOLD, DOUT=0, nDRDY=1, frame aborted, FRAME_CNT=0.
//  NEXT_DATA changes mid-frame: no effect until next fc=0 (shadow register).
//  Simultaneous fc=0 and nSYNC_IN==0: sync wins, no nDRDY pulse.
// CONFIGURATION
//  ADC_TEST_PATTERN_EN defined: TEST_MODE port exists; when TEST_MODE=1 at fc=0, ch c latches
//   {c[7:0], FRAME_CNT_next[CH_W-9:0] zero-extended}. TEST_MODE=0 or macro undefined: NEXT_DATA used.
//  Macro undefined: no TEST_MODE port, no pattern logic.
// STRUCTURE
//  Package adc_sim_pkg: state enum typedef (SYNC_HOLD, SYNC_WAIT, SHIFT, GAP), clog2-based counter widths, lane-map function ch_of(lane, slot).
//  Sub-module adc_lane_shifter (CPL*CH_W-bit parallel-load, MSB-first shift register), one instance per lane via generate.
//  Top holds FSM, frame/delay counters, FRAME_CNT, optional pattern mux.
// TESTING
//  1 Defaults, reset 3 cycles, nSYNC_IN=1, NEXT_DATA[c]=32'hC0DE_0000+c
//    -> nDRDY low 16 cycles after RST release, lane0 shows 0xC0DE0000 then 0xC0DE0001, GAP zeros, next nDRDY 256 cycles later.
//  2 nSYNC_IN low 5 cycles at fc=40 -> DOUT=0 next edge, no nDRDY until 16 cycles after rise, FRAME_CNT restarts at 1.
//  3 NEXT_DATA changed at fc=10 -> current frame bits unchanged, new value appears in following frame.
//  4 N_CH=6, N_LANES=2, CH_W=24, FRAME_CYCLES=73 -> 72 data bits + 1 gap cycle per frame; lane1 = ch3,4,5.
//  5 ADC_TEST_PATTERN_EN, TEST_MODE=1 -> frame 3, ch5 word = 32'h0500_0003.
//  6 RST asserted at fc=100 -> next edge nDRDY=1, DOUT=0, FRAME_CNT=0; restart behaves as test 1.

Source files
------------

// File: rtl/adc_sim_pkg.sv
// adc_sim_pkg: state encoding, counter sizing and lane map shared by the multi-lane ADC model
package adc_sim_pkg;

    typedef enum logic [1:0] {SYNC_HOLD, SYNC_WAIT, SHIFT, GAP} state_t;

    localparam int FRAME_CNT_W = 16;
    localparam int TAG_W       = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // lane l carries channels l*cpl .. l*cpl+cpl-1, lowest channel in slot 0
    function automatic int ch_of(input int lane, input int slot, input int cpl);
        return lane * cpl + slot;
    endfunction

endpackage

// File: rtl/adc_lane_shifter.sv
// adc_lane_shifter: parallel-load, MSB-first shift register driving one DOUT lane
module adc_lane_shifter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         q
);

    logic [W-1:0] sr;

    // zeros shift in behind the data, so the lane idles low once the word is out
    always_ff @(posedge clk) begin
        if (clr)
            sr <= '0;
        else if (load)
            sr <= d;
        else
            sr <= {sr[W-2:0], 1'b0};
    end

    assign q = sr[W-1];

endmodule

// File: rtl/adc_multilane_data_sim.sv
// adc_multilane_data_sim: multi-lane serial ADC output model with sync-restartable frame timing
// Optional generated test pattern (TEST_MODE port) when ADC_TEST_PATTERN_EN is defined.
module adc_multilane_data_sim
    import adc_sim_pkg::*;
#(
    parameter int N_CH         = 8,
    parameter int CH_W         = 32,
    parameter int N_LANES      = 4,
    parameter int FRAME_CYCLES = 256,
    parameter int SYNC_DELAY   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   nSYNC_IN,
    input  logic [CH_W-1:0]        NEXT_DATA [N_CH-1:0],
`ifdef ADC_TEST_PATTERN_EN
    input  logic                   TEST_MODE,
`endif
    output logic                   nDRDY,
    output logic [N_LANES-1:0]     DOUT,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

    localparam int CPL  = N_CH / N_LANES;
    localparam int BITS = CPL * CH_W;
    localparam int FC_W = cnt_w(FRAME_CYCLES);
    localparam int DC_W = cnt_w(SYNC_DELAY);

    if (N_CH % N_LANES != 0) begin : g_chk_lanes
        $error("N_CH must be a multiple of N_LANES");
    end
    if (CH_W < 16) begin : g_chk_width
        $error("CH_W must be at least 16");
    end
    if (FRAME_CYCLES < BITS + 1) begin : g_chk_frame
        $error("FRAME_CYCLES must be at least CPL*CH_W+1");
    end
    if (SYNC_DELAY < 1) begin : g_chk_delay
        $error("SYNC_DELAY must be at least 1");
    end

    state_t                 state;
    logic [FC_W-1:0]        fc;
    logic [FC_W-1:0]        fc_inc;
    logic [DC_W-1:0]        dcnt;
    logic [FRAME_CNT_W-1:0] cnt_next;
    logic                   idle;
    logic                   start;
    logic                   clr;
    logic [CH_W-1:0]        word [N_CH-1:0];

    assign fc_inc   = fc + 1'b1;
    assign cnt_next = FRAME_CNT + 1'b1;
    assign idle     = (state == SYNC_HOLD) || (state == SYNC_WAIT);
    // SYNC_HOLD behaves as delay count 0, so the first high sample already counts
    assign start    = nSYNC_IN && (idle ? dcnt == DC_W'(SYNC_DELAY - 1) : fc == FC_W'(FRAME_CYCLES - 1));
    assign clr      = RST || !nSYNC_IN;

`ifdef ADC_TEST_PATTERN_EN
    always_comb begin
        for (int c = 0; c < N_CH; c++)
            word[c] = TEST_MODE ? {TAG_W'(c), (CH_W - TAG_W)'(cnt_next)} : NEXT_DATA[c];
    end
`else
    always_comb begin
        for (int c = 0; c < N_CH; c++)
            word[c] = NEXT_DATA[c];
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= SYNC_WAIT;
            dcnt      <= '0;
            fc        <= '0;
            FRAME_CNT <= '0;
            nDRDY     <= 1'b1;
        end else if (!nSYNC_IN) begin
            state     <= SYNC_HOLD;
            dcnt      <= '0;
            fc        <= '0;
            FRAME_CNT <= '0;
            nDRDY     <= 1'b1;
        end else if (start) begin
            state     <= SHIFT;
            dcnt      <= '0;
            fc        <= '0;
            FRAME_CNT <= cnt_next;
            nDRDY     <= 1'b0;
        end else if (idle) begin
            state     <= SYNC_WAIT;
            dcnt      <= dcnt + 1'b1;
            nDRDY     <= 1'b1;
        end else begin
            state     <= (fc_inc < FC_W'(BITS)) ? SHIFT : GAP;
            fc        <= fc_inc;
            nDRDY     <= 1'b1;
        end
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        logic [BITS-1:0] lw;
        always_comb begin
            lw = '0;
            for (int s = 0; s < CPL; s++)
                lw[BITS-1-s*CH_W -: CH_W] = word[ch_of(l, s, CPL)];
        end
        adc_lane_shifter #(.W(BITS)) u_shift (
            .clk  (CLK),
            .clr  (clr),
            .load (start),
            .d    (lw),
            .q    (DOUT[l])
        );
    end

endmodule

// File: tb/tb_adc_multilane_data_sim.sv
// tb_adc_multilane_data_sim: randomized bench for default and 6ch/2-lane/24-bit/73-cycle configurations
// Reference computes every output from the count of edges since the last reset/sync release.
module tb_adc_multilane_data_sim;

    localparam int SD = 16;
    localparam int NCH [2] = '{8, 6};
    localparam int NL  [2] = '{4, 2};
    localparam int CW  [2] = '{32, 24};
    localparam int FCY [2] = '{256, 73};

    logic        CLK;
    logic        RST;
    logic        nsync;
    logic        tm;
    logic [31:0] data_a [7:0];
    logic [23:0] data_b [5:0];
    logic        drdy_a, drdy_b;
    logic [3:0]  dout_a;
    logic [1:0]  dout_b;
    logic [15:0] cnt_a, cnt_b;

    int          n;
    int          n_chk;
    int          n_fail;
    logic [31:0] lat [2][8];

    adc_multilane_data_sim u_dut_a (
        .CLK       (CLK),
        .RST       (RST),
        .nSYNC_IN  (nsync),
        .NEXT_DATA (data_a),
`ifdef ADC_TEST_PATTERN_EN
        .TEST_MODE (tm),
`endif
        .nDRDY     (drdy_a),
        .DOUT      (dout_a),
        .FRAME_CNT (cnt_a)
    );

    adc_multilane_data_sim #(
        .N_CH         (6),
        .CH_W         (24),
        .N_LANES      (2),
        .FRAME_CYCLES (73),
        .SYNC_DELAY   (SD)
    ) u_dut_b (
        .CLK       (CLK),
        .RST       (RST),
        .nSYNC_IN  (nsync),
        .NEXT_DATA (data_b),
`ifdef ADC_TEST_PATTERN_EN
        .TEST_MODE (tm),
`endif
        .nDRDY     (drdy_b),
        .DOUT      (dout_b),
        .FRAME_CNT (cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_dout(input int d, input int fc);
        logic [3:0] r;
        int cpl, w;
        r   = '0;
        cpl = NCH[d] / NL[d];
        w   = CW[d];
        if (fc < cpl * w)
            for (int l = 0; l < NL[d]; l++)
                r[l] = lat[d][l * cpl + fc / w][w - 1 - fc % w];
        return r;
    endfunction

    // one clock: the DUT samples current inputs at posedge, outputs are checked at negedge
    task automatic tick();
        int k, fc, fr;
        logic       e_drdy;
        logic [3:0] e_dout;
        logic [15:0] e_cnt;
        @(negedge CLK);
        if (RST || !nsync) n = 0;
        else n++;
        for (int d = 0; d < 2; d++) begin
            if (n >= SD) begin
                k  = n - SD;
                fc = k % FCY[d];
                fr = k / FCY[d] + 1;
                if (fc == 0)
                    for (int c = 0; c < NCH[d]; c++)
                        lat[d][c] = (d == 0) ? (tm ? {8'(c), 24'(16'(fr))} : data_a[c]) : {8'h0, data_b[c]};
                e_drdy = (fc != 0);
                e_dout = exp_dout(d, fc);
                e_cnt  = 16'(fr);
            end else begin
                e_drdy = 1'b1;
                e_dout = '0;
                e_cnt  = '0;
            end
            if (d == 0) begin
                check("a.nDRDY", 64'(drdy_a), 64'(e_drdy));
                check("a.DOUT", 64'(dout_a), 64'(e_dout));
                check("a.FRAME_CNT", 64'(cnt_a), 64'(e_cnt));
            end else begin
                check("b.nDRDY", 64'(drdy_b), 64'(e_drdy));
                check("b.DOUT", 64'(dout_b), 64'(e_dout[1:0]));
                check("b.FRAME_CNT", 64'(cnt_b), 64'(e_cnt));
            end
        end
    endtask

    task automatic wait_fc(input int v);
        for (int i = 0; i < 600 && !(n >= SD && (n - SD) % FCY[0] == v); i++)
            tick();
    endtask

    task automatic shuffle();
        for (int c = 0; c < 8; c++) data_a[c] = $urandom;
        for (int c = 0; c < 6; c++) data_b[c] = 24'($urandom);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        n      = 0;
        RST    = 1'b1;
        nsync  = 1'b1;
        tm     = 1'b0;
        for (int c = 0; c < 8; c++) data_a[c] = 32'hC0DE_0000 + c;
        for (int c = 0; c < 6; c++) data_b[c] = 24'hDE_0000 + 24'(c);
        repeat (3) tick();
        RST = 1'b0;
        repeat (SD + 2 * 256 + 10) tick();

        wait_fc(40);
        nsync = 1'b0;
        repeat (5) tick();
        nsync = 1'b1;
        repeat (SD + 300) tick();

        wait_fc(10);
        shuffle();
        repeat (600) tick();

        wait_fc(255);
        nsync = 1'b0;
        tick();
        nsync = 1'b1;
        repeat (SD + 100) tick();

        wait_fc(100);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (SD + 600) tick();

`ifdef ADC_TEST_PATTERN_EN
        tm    = 1'b1;
        nsync = 1'b0;
        tick();
        nsync = 1'b1;
        repeat (SD + 3 * 256 + 20) tick();
        tm = 1'b0;
`endif

        for (int i = 0; i < 6000; i++) begin
            case ($urandom_range(0, 399))
                0, 1:    nsync = 1'b0;
                2:       RST = 1'b1;
                default: begin
                    nsync = 1'b1;
                    RST   = 1'b0;
                end
            endcase
            if ($urandom_range(0, 15) == 0) shuffle();
`ifdef ADC_TEST_PATTERN_EN
            if ($urandom_range(0, 255) == 0) tm = ~tm;
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
